hu_rr_arbiter: RTL and testbench

//  Round-robin arbiter with valid/ready handshake; drives the one-hot select of hu_selector.
//  N requesters compete for one output channel; grant is one-hot, registered, and held until the beat transfers.

---
 rtl/hu_arb_pkg.sv | 29 ++
 rtl/hu_rr_pick.sv | 57 +++++
 rtl/hu_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_hu_rr_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hu_arb_pkg.sv
// -----------------------------------------------------------------------------
// hu_arb_pkg
//   Shared types and helpers for the hu_rr_arbiter block.
//   - hu_arb_state_t : arbiter FSM state (IDLE = no grant held, BUSY = grant held)
//   - HU_ARB_MAX_WIDTH : largest supported requester count
//   - onehot_to_idx  : index of the set bit in a one-hot vector (0 when zero)
// -----------------------------------------------------------------------------
package hu_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } hu_arb_state_t;

  localparam int HU_ARB_MAX_WIDTH = 32;

  // The caller guarantees at most one bit is set. With a zero vector the
  // result is 0, which is harmless because the index is only used together
  // with a non-zero pick.
  function automatic int onehot_to_idx(input logic [HU_ARB_MAX_WIDTH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < HU_ARB_MAX_WIDTH; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hu_rr_pick.sv
// -----------------------------------------------------------------------------
// hu_rr_pick
//   Combinational round-robin picker. Searches req starting one position
//   above ptr, ascending, wrapping from width-1 back to 0. The first set
//   request wins.
//
//   Parameters
//     width : number of requesters (1..32)
//     iw    : width of the index bus (derived, do not override)
//   Ports
//     req   in   width  request vector
//     ptr   in   iw     index of the most recently served requester
//     pick  out  width  one-hot winner (zero when no request)
//     idx   out  iw     index of the winner (0 when no request)
//     any   out  1      at least one request present
// -----------------------------------------------------------------------------
module hu_rr_pick
  import hu_arb_pkg::*;
#(
  parameter int width = 4,
  parameter int iw    = (width > 1) ? $clog2(width) : 1
) (
  input  logic [width-1:0] req,
  input  logic [iw-1:0]    ptr,
  output logic [width-1:0] pick,
  output logic [iw-1:0]    idx,
  output logic             any
);

  logic                        found;
  int                          pos;
  logic [iw-1:0]               pos_idx;
  logic [HU_ARB_MAX_WIDTH-1:0] pick_ext;

  always_comb begin
    pick    = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < width; k++) begin
      // ptr is always a valid index, so ptr+1+k stays below 2*width and a
      // single subtraction is enough to wrap.
      pos = int'(ptr) + 1 + k;
      if (pos >= width) pos = pos - width;
      pos_idx = iw'(pos);
      if (!found && req[pos_idx]) begin
        pick[pos_idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign pick_ext = HU_ARB_MAX_WIDTH'(pick);
  assign idx      = iw'(onehot_to_idx(pick_ext));
  assign any      = |req;

endmodule

// File: rtl/hu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hu_rr_arbiter
//   Round-robin arbiter with valid/ready handshake. The registered one-hot
//   grant drives the sel input of hu_selector directly downstream.
//
//   Handshake: a beat transfers on a rising edge where out_valid and
//   out_ready are both high. out_valid is the granted requester's req_valid;
//   req_ready is the grant gated by out_ready, so exactly the granted
//   requester sees its own transfer in the same cycle. A requester that
//   raises req_valid keeps it high until it sees req_ready.
//
//   Optional feature (macro HU_RR_ARBITER_LAST_EN):
//     defined   : req_last/out_last ports exist; the grant is locked to one
//                 requester until a transfer with out_last=1 (packet lock).
//     undefined : every transfer re-arbitrates (single-beat packets).
//
//   Parameters
//     width      : number of requesters, 1..32
//   Ports
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     req_valid  in   width  per-requester valid
//     req_ready  out  width  grant & {width{out_ready}}
//     req_last   in   width  per-requester end-of-packet (LAST_EN only)
//     grant      out  width  registered one-hot (or zero) grant
//     out_valid  out  1      req_valid of the granted requester
//     out_ready  in   1      downstream ready
//     out_last   out  1      req_last of the granted requester (LAST_EN only)
//     dbg_state  out  1      current FSM state (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module hu_rr_arbiter
  import hu_arb_pkg::*;
#(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] req_valid,
  output logic [width-1:0] req_ready,
`ifdef HU_RR_ARBITER_LAST_EN
  input  logic [width-1:0] req_last,
  output logic             out_last,
`endif
  output logic [width-1:0] grant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dbg_state
);

  localparam int iw = (width > 1) ? $clog2(width) : 1;
  localparam logic [iw-1:0] ptr_rst = iw'(width - 1);

  hu_arb_state_t    state;
  logic [iw-1:0]    ptr;
  logic [width-1:0] pick;
  logic [iw-1:0]    pick_idx;
  logic             pick_any;
  logic             xfer;
  logic             rearb;
  logic             release_grant;

  hu_rr_pick #(
    .width (width),
    .iw    (iw)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // grant is zero in IDLE, so out_valid is naturally low there.
  assign out_valid = |(grant & req_valid);
  assign req_ready = grant & {width{out_ready}};
  assign xfer      = out_valid & out_ready;
  assign dbg_state = state;

`ifdef HU_RR_ARBITER_LAST_EN
  // Packet lock: only the final beat of a packet frees the channel, and a
  // bubble in the middle of a packet keeps the grant.
  assign out_last      = |(grant & req_last);
  assign rearb         = xfer & out_last;
  assign release_grant = 1'b0;
`else
  // Single-beat packets: every transfer re-arbitrates; a granted requester
  // that has gone quiet gives the channel back.
  assign rearb         = xfer;
  assign release_grant = ~out_valid;
`endif

  // ptr records the last winner so the search starts just above it; the
  // requester just served therefore ranks lowest on the next pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      grant <= '0;
      ptr   <= ptr_rst;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant <= pick;
            ptr   <= pick_idx;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (rearb) begin
            if (pick_any) begin
              grant <= pick;
              ptr   <= pick_idx;
            end else begin
              grant <= '0;
              state <= ARB_IDLE;
            end
          end else if (release_grant) begin
            grant <= '0;
            state <= ARB_IDLE;
          end
          // Otherwise a beat is stalled by out_ready: hold everything.
        end
        default: begin
          grant <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hu_rr_arbiter
//   Directed self-checking bench for hu_rr_arbiter (width=4). Requester data
//   passes through a behavioural one-hot selector driven by grant, and the
//   selected data is compared with the data of the expected winner.
//   Works with and without HU_RR_ARBITER_LAST_EN.
// -----------------------------------------------------------------------------
module tb_hu_rr_arbiter;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0] req_valid;
  logic [W-1:0] req_ready;
  logic [W-1:0] grant;
  logic         out_valid;
  logic         out_ready;
  logic         dbg_state;
`ifdef HU_RR_ARBITER_LAST_EN
  logic [W-1:0] req_last;
  logic         out_last;
`endif

  hu_rr_arbiter #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
`ifdef HU_RR_ARBITER_LAST_EN
    .req_last  (req_last),
    .out_last  (out_last),
`endif
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Selector model: requester i presents data 8'hA0+i.
  logic [7:0] sel_q;
  always_comb begin
    sel_q = '0;
    for (int i = 0; i < W; i++) begin
      if (grant[i]) sel_q = sel_q | 8'(8'hA0 + i);
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
`ifdef HU_RR_ARBITER_LAST_EN
    req_last  = 4'b1111;
`endif
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] eg;

    // 1. Reset, no requests: nothing ever granted.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_grant", 32'(grant), 32'h0);
      check("t1_out_valid", 32'(out_valid), 32'h0);
      check("t1_req_ready", 32'(req_ready), 32'h0);
      check("t1_state", 32'(dbg_state), 32'h0);
    end

    // 2. All requesting, out_ready high: rotation after one-cycle latency.
    req_valid = 4'b1111;
    #1;
    check("t2_latency_out_valid", 32'(out_valid), 32'h0);
    check("t2_latency_grant", 32'(grant), 32'h0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      eg = exp_q.pop_front();
      check("t2_grant", 32'(grant), 32'(eg));
      check("t2_req_ready", 32'(req_ready), 32'(eg));
      check("t2_sel_data", 32'(sel_q), 32'(8'hA0 + (k % 4)));
      check("t2_state", 32'(dbg_state), 32'h1);
    end

    // 3. Stall with grant 0010: held, no ready; then release moves to 0100.
    tick();
    check("t3_grant_pre", 32'(grant), 32'h2);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_req_ready_stall", 32'(req_ready), 32'h0);
      check("t3_out_valid_stall", 32'(out_valid), 32'h1);
      tick();
      check("t3_grant_hold", 32'(grant), 32'h2);
    end
    out_ready = 1'b1;
    #1;
    check("t3_req_ready_go", 32'(req_ready), 32'h2);
    tick();
    check("t3_grant_next", 32'(grant), 32'h4);

    // 4. Lone requester 3 wins every cycle; dropping valid releases.
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_grant_alone", 32'(grant), 32'h8);
    end
    req_valid = 4'b0000;
    #1;
    check("t4_out_valid_drop", 32'(out_valid), 32'h0);
    tick();
`ifdef HU_RR_ARBITER_LAST_EN
    // A bubble never releases a locked grant.
    check("t4_grant_after_drop", 32'(grant), 32'h8);
    check("t4_state_after_drop", 32'(dbg_state), 32'h1);
`else
    check("t4_grant_after_drop", 32'(grant), 32'h0);
    check("t4_state_after_drop", 32'(dbg_state), 32'h0);
`endif

    // 5. Requesters 0 and 1 competing.
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0011;
`ifdef HU_RR_ARBITER_LAST_EN
    req_last = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_pkt_grant", 32'(grant), 32'h1);
      if (k == 2) req_last = 4'b0001;
      #1;
      check("t5_out_last", 32'(out_last), (k == 2) ? 32'h1 : 32'h0);
    end
    tick();
    check("t5_pkt_next", 32'(grant), 32'h2);
    req_valid = 4'b0001;
    tick();
    check("t5_midpkt_bubble_hold", 32'(grant), 32'h2);
`else
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_alternate", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
    end
`endif

    // 6. Async reset during a stalled grant of 0100.
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b0100;
    tick();
    check("t6_grant_setup", 32'(grant), 32'h4);
    tick();
    check("t6_grant_held", 32'(grant), 32'h4);
    req_valid = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_grant_async", 32'(grant), 32'h0);
    check("t6_out_valid_async", 32'(out_valid), 32'h0);
    check("t6_state_async", 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_first_grant", 32'(grant), 32'h1);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
